spi_burst_ram: RTL

//  Parametrised command-decoded single-port RAM behind the SPI slave. Consumes

---
 rtl/spi_ram_pkg.sv | 11 +
 rtl/spi_burst_ram_if.sv | 15 +
 rtl/sp_ram_core.sv | 22 ++
 rtl/spi_burst_ram.sv | 120 ++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command encoding for the SPI burst RAM.
package spi_ram_pkg;

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_SET_WA = 2'b00;
  localparam cmd_t CMD_WRITE  = 2'b01;
  localparam cmd_t CMD_SET_RA = 2'b10;
  localparam cmd_t CMD_READ   = 2'b11;

endpackage

// File: rtl/spi_burst_ram_if.sv
// Frame and response signals between the SPI slave and the burst RAM.
interface spi_burst_ram_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              cmd_err;

  modport master (output din, rx_valid, input dout, tx_valid, cmd_err);
  modport slave  (input din, rx_valid, output dout, tx_valid, cmd_err);

endinterface

// File: rtl/sp_ram_core.sv
// Single-port storage array with registered read data.
module sp_ram_core #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_burst_ram.sv
// Command-decoded burst RAM behind the SPI slave.
// Optional address auto-increment: define SPI_RAM_AUTO_INC_EN.
module spi_burst_ram
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input logic               clk,
  input logic               rst_n,
  spi_burst_ram_if.slave    bus
);

  if (ADDR_W > DATA_W) begin : g_bad_addr_w
    $error("spi_burst_ram: ADDR_W must not exceed DATA_W");
  end
  if (MEM_DEPTH > 2**ADDR_W) begin : g_bad_depth
    $error("spi_burst_ram: MEM_DEPTH must not exceed 2**ADDR_W");
  end

  cmd_t              cmd;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] pay_addr;
  logic              in_range;

  logic [ADDR_W-1:0] wr_addr, rd_addr, mem_addr;
  logic              wr_ok, rd_ok;
  logic              mem_we, mem_re, err, wa_load, ra_load;
  logic [DATA_W-1:0] rdata_p0;
  logic              vld_p0, vld_p1, err_p0;
  logic [DATA_W-1:0] dout_p1;

  assign cmd      = cmd_t'(bus.din[DATA_W+1:DATA_W]);
  assign payload  = bus.din[DATA_W-1:0];
  assign pay_addr = payload[ADDR_W-1:0];
  assign in_range = 32'(pay_addr) < 32'(MEM_DEPTH);

`ifdef SPI_RAM_AUTO_INC_EN
  // Wrap at the populated depth, not at the address-space limit.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (32'(a) == 32'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction
`endif

  // Frames during reset are ignored so a reset cannot coincide with a write.
  always_comb begin
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = rd_addr;
    err      = 1'b0;
    wa_load  = 1'b0;
    ra_load  = 1'b0;
    if (rst_n && bus.rx_valid) begin
      unique case (cmd)
        CMD_SET_WA: if (in_range) wa_load = 1'b1; else err = 1'b1;
        CMD_WRITE: begin
          if (wr_ok) begin
            mem_we   = 1'b1;
            mem_addr = wr_addr;
          end else begin
            err = 1'b1;
          end
        end
        CMD_SET_RA: if (in_range) ra_load = 1'b1; else err = 1'b1;
        CMD_READ:   if (rd_ok) mem_re = 1'b1; else err = 1'b1;
        default:    err = 1'b0;
      endcase
    end
  end

  sp_ram_core #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_core (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(payload),
    .rdata(rdata_p0)
  );

  // Stage p0: array read issued; stage p1: data presented with tx_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
      wr_ok   <= 1'b0;
      rd_ok   <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      err_p0  <= 1'b0;
      dout_p1 <= '0;
    end else begin
      err_p0 <= err;
      vld_p0 <= mem_re;
      vld_p1 <= vld_p0;
      if (vld_p0) dout_p1 <= rdata_p0;
      if (wa_load) begin
        wr_addr <= pay_addr;
        wr_ok   <= 1'b1;
      end
      if (ra_load) begin
        rd_addr <= pay_addr;
        rd_ok   <= 1'b1;
      end
`ifdef SPI_RAM_AUTO_INC_EN
      if (mem_we) wr_addr <= next_addr(wr_addr);
      if (mem_re) rd_addr <= next_addr(rd_addr);
`endif
    end
  end

  assign bus.dout     = dout_p1;
  assign bus.tx_valid = vld_p1;
  assign bus.cmd_err  = err_p0;

endmodule
